serial_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor computing `diff = a - b - bin` one bit per clock through a single full-subtractor cell. It is the subtract-direction counterpart of the team's structural 4-bit ripple-carry adder. It trades the adder's N parallel cells for one cell plus a shift/count datapath, which makes it suitable for area-constrained arithmetic units. A start/done handshake lets a controller launch one operation at a time.

---
 rtl/arith_pkg.sv | 24 ++
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package for the serial arithmetic blocks.
// Holds the common state encoding used by the serial datapath FSMs and
// a clog2 helper for sizing counters from parameters.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Ceiling log2, usable in constant (parameter) expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit gate-level full subtractor: diff = a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   diff      : difference bit
//   bout      : borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic axb;
    logic borrow_gen;
    logic borrow_prop;

    assign axb         = a ^ b;
    assign diff        = axb ^ bin;
    // Borrow is generated when a=0,b=1, and propagated when a==b.
    assign borrow_gen  = ~a & b;
    assign borrow_prop = ~axb & bin;
    assign bout        = borrow_gen | borrow_prop;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = (a - b - bin) mod 2^WIDTH,
// one bit per clock through a single full_subtractor cell.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : launch request, honoured only while ready = 1
//   a, b, bin       : operands and borrow-in, captured on the accepted start
//   ready/busy/done : IDLE / SHIFT / DONE state decodes (done is a 1-cycle pulse)
//   diff, bout      : registered result, held until the next completion
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, diff_reg;
    logic [WIDTH-1:0] a_shift, b_shift, res_next;
    logic             br_reg, bout_reg;
    logic [CW-1:0]    cnt_reg;
    logic             bit_diff, bit_borrow;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (br_reg),
        .diff (bit_diff),
        .bout (bit_borrow)
    );

    // Right-shift networks: operands consume LSB first, and the fresh
    // difference bit enters the result register at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shift[gi]  = a_reg[gi+1];
            assign b_shift[gi]  = b_reg[gi+1];
            assign res_next[gi] = res_reg[gi+1];
        end
    endgenerate
    assign a_shift[WIDTH-1]  = 1'b0;
    assign b_shift[WIDTH-1]  = 1'b0;
    assign res_next[WIDTH-1] = bit_diff;

    // The counter still holds WIDTH-1 during the final shift cycle.
    assign last_bit = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        br_reg  <= bin;
                        res_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_shift;
                    b_reg   <= b_shift;
                    br_reg  <= bit_borrow;
                    res_reg <= res_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Publish the result on the edge that enters DONE so it
                    // is valid for the whole done pulse.
                    if (last_bit) begin
                        diff_reg <= res_next;
                        bout_reg <= bit_borrow;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       start4, bin4, ready4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    logic       start8, bin8, ready8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .ready (ready4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one WIDTH=4 operation; lat counts rising edges from the edge
    // following the start drive up to the edge after which done is seen.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin, output int lat);
        @(negedge clk);
        start4 = 1'b1; a4 = ta; b4 = tb_v; bin4 = tbin;
        lat = 0;
        @(posedge clk); lat = 1;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        while (done4 !== 1'b1 && lat < 30) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb_v; bin8 = tbin;
        lat = 0;
        @(posedge clk); lat = 1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        while (done8 !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic ready_early;
        logic [8:0] model;

        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0};
        vecs[5] = '{4'd5,  4'd5,  1'b1, 4'hF,  1'b1};
        vecs[6] = '{4'd7,  4'd2,  1'b1, 4'd4,  1'b0};
        vecs[7] = '{4'd15, 4'd0,  1'b1, 4'hE,  1'b0};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready4), 32'd1);
        check("reset_busy",  32'(busy4),  32'd0);
        check("reset_done",  32'(done4),  32'd0);
        check("reset_diff",  32'(diff4),  32'd0);
        check("reset_bout",  32'(bout4),  32'd0);

        // Table-driven WIDTH=4 vectors
        for (int i = 0; i < 8; i++) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            $display("w4 op a=%0d b=%0d bin=%0d -> diff=%0h bout=%0d lat=%0d",
                     vecs[i].a, vecs[i].b, vecs[i].bin, diff4, bout4, lat);
            check("vec_latency", 32'(lat),   32'd5);
            check("vec_diff",    32'(diff4), 32'(vecs[i].diff));
            check("vec_bout",    32'(bout4), 32'(vecs[i].bout));
            @(negedge clk);
            check("vec_done_pulse", 32'(done4),  32'd0);
            check("vec_ready_back", 32'(ready4), 32'd1);
        end

        // Busy rejection: a second start during SHIFT must be ignored
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        check("rej_ready_low", 32'(ready4), 32'd0);
        check("rej_busy_high", 32'(busy4),  32'd1);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd7;
        @(negedge clk);
        start4 = 1'b0;
        ndone = 0;
        ready_early = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done4 === 1'b1) begin
                ndone++;
                check("rej_diff", 32'(diff4), 32'd7);
                check("rej_bout", 32'(bout4), 32'd0);
            end
            if (ndone == 0 && ready4 === 1'b1) ready_early = 1'b1;
            @(negedge clk);
        end
        $display("w4 busy-rejection ops: done pulses=%0d diff=%0h", ndone, diff4);
        check("rej_done_count", 32'(ndone), 32'd1);
        check("rej_ready_early", 32'(ready_early), 32'd0);

        // Reset during the second SHIFT cycle
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_diff",  32'(diff4),  32'd0);
        check("midrst_bout",  32'(bout4),  32'd0);
        check("midrst_ready", 32'(ready4), 32'd1);
        check("midrst_busy",  32'(busy4),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) ndone++;
        end
        $display("w4 reset-abort op: done pulses after reset=%0d", ndone);
        check("midrst_no_done", 32'(ndone), 32'd0);
        op4(4'd12, 4'd5, 1'b0, lat);
        $display("w4 op a=12 b=5 bin=0 -> diff=%0h bout=%0d lat=%0d", diff4, bout4, lat);
        check("post_rst_latency", 32'(lat),   32'd5);
        check("post_rst_diff",    32'(diff4), 32'd7);
        check("post_rst_bout",    32'(bout4), 32'd0);

        // WIDTH=8 random sweep against a 9-bit arithmetic model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbin = 1'($urandom);
            if (i == 0) begin ra = 8'd0; rb = 8'd255; rbin = 1'b1; end
            if (i == 1) begin ra = 8'd255; rb = 8'd0; rbin = 1'b0; end
            model = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            op8(ra, rb, rbin, lat);
            $display("w8 op a=%0d b=%0d bin=%0d -> diff=%0h bout=%0d lat=%0d",
                     ra, rb, rbin, diff8, bout8, lat);
            check("w8_latency", 32'(lat),   32'd9);
            check("w8_diff",    32'(diff8), 32'(model[7:0]));
            check("w8_bout",    32'(bout8), 32'(model[8]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
